// File: rtl/clock_display_pkg.sv
// Shared constants, types and the 7-segment font for the clock display scanner.
// Pure declarations: no logic, no latency.
// No flow control.
package clock_display_pkg;

    localparam int NUM_DIGITS = 6;

    // Segment patterns are {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // One captured time sample, displayed as HH MM SS.
    typedef struct packed {
        logic [3:0] hours;
        logic [5:0] minutes;
        logic [5:0] seconds;
    } time_t;

    // Decimal digit to segments. Anything above 9 is blanked.
    function automatic logic [6:0] seg_font(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'h3F;
            4'd1:    pattern = 7'h06;
            4'd2:    pattern = 7'h5B;
            4'd3:    pattern = 7'h4F;
            4'd4:    pattern = 7'h66;
            4'd5:    pattern = 7'h6D;
            4'd6:    pattern = 7'h7D;
            4'd7:    pattern = 7'h07;
            4'd8:    pattern = 7'h7F;
            4'd9:    pattern = 7'h6F;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/bin2bcd60.sv
// Binary 0..63 to two BCD digits, with an out-of-range flag for values >= 60.
// Purely combinational, zero latency.
// No flow control.
// Ports: bin (6-bit binary in), tens/ones (BCD digits out), oor (bin >= 60).
module bin2bcd60 (
    input  logic [5:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       oor
);

    assign tens = 4'(bin / 6'd10);
    assign ones = 4'(bin % 6'd10);
    assign oor  = (bin >= 6'd60);

endmodule

// File: rtl/clock_display_scanner.sv
// Scans a captured HH:MM:SS time onto a 6-digit multiplexed 7-segment display.
// Outputs registered: seg/an follow the digit index by one cycle; first digit 2 cycles after reset release.
// No backpressure: free-running scan, the time inputs are sampled once per frame.
// Ports: clk, rst (async active-low), seconds/minutes/hours (binary time in),
//        seg {g,f,e,d,c,b,a} active-high, an active-low one-hot (bit0 = seconds ones),
//        frame_start (one-cycle pulse with the first cycle of digit 0).
// Build option: LEADING_ZERO_BLANK_EN blanks a zero hours-tens digit (its anode still scans).
module clock_display_scanner
    import clock_display_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] seconds,
    input  logic [5:0] minutes,
    input  logic [3:0] hours,
    output logic [6:0] seg,
    output logic [5:0] an,
    output logic       frame_start
);

    localparam int               DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);
    localparam logic [5:0]       AN_IDX0  = 6'h3E;

    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       idx_q, idx_d;
    time_t            snap_q, snap_d;
    logic             load_q, load_d;
    logic [6:0]       seg_q, seg_d;
    logic [5:0]       an_q, an_d;
    logic             fs_q, fs_d;
    logic             tick;

    logic [3:0] sec_tens, sec_ones, min_tens, min_ones, hr_tens, hr_ones;
    logic       sec_oor, min_oor, hr_oor_unused;
    logic [3:0] digit_val;
    logic       digit_dash;
    logic [6:0] digit_seg;

    // load_q marks the single cycle after reset release: the snapshot is taken
    // and the prescaler holds, so the first digit slot is a full SCAN_DIV long.
    assign tick = !load_q && (div_q == DIV_LAST);

    always_comb begin
        load_d = 1'b0;
        div_d  = div_q;
        idx_d  = idx_q;
        snap_d = snap_q;
        if (!load_q) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end
        // Capture only at frame boundaries so one frame never mixes two times.
        if (load_q || (tick && idx_q == IDX_LAST)) begin
            snap_d = '{hours: hours, minutes: minutes, seconds: seconds};
        end
    end

    bin2bcd60 u_sec (.bin(snap_q.seconds),         .tens(sec_tens), .ones(sec_ones), .oor(sec_oor));
    bin2bcd60 u_min (.bin(snap_q.minutes),         .tens(min_tens), .ones(min_ones), .oor(min_oor));
    bin2bcd60 u_hr  (.bin({2'b00, snap_q.hours}),  .tens(hr_tens),  .ones(hr_ones),  .oor(hr_oor_unused));

    always_comb begin
        digit_val  = 4'd0;
        digit_dash = 1'b0;
        case (idx_q)
            3'd0: begin digit_val = sec_ones; digit_dash = sec_oor; end
            3'd1: begin digit_val = sec_tens; digit_dash = sec_oor; end
            3'd2: begin digit_val = min_ones; digit_dash = min_oor; end
            3'd3: begin digit_val = min_tens; digit_dash = min_oor; end
            3'd4: begin digit_val = hr_ones;  end
            3'd5: begin digit_val = hr_tens;  end
            default: ;
        endcase
        digit_seg = digit_dash ? SEG_DASH : seg_font(digit_val);
`ifdef LEADING_ZERO_BLANK_EN
        if (idx_q == IDX_LAST && digit_val == 4'd0) begin
            digit_seg = SEG_BLANK;
        end
`endif
    end

    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = 6'h3F;
        fs_d  = 1'b0;
        // Stay dark while the snapshot is still being taken.
        if (!load_q) begin
            seg_d = digit_seg;
            an_d  = ~(6'b000001 << idx_q);
            // Pulse only on the cycle digit 0 first appears.
            fs_d  = (idx_q == 3'd0) && (an_q != AN_IDX0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q  <= '0;
            idx_q  <= 3'd0;
            snap_q <= '0;
            load_q <= 1'b1;
            seg_q  <= SEG_BLANK;
            an_q   <= 6'h3F;
            fs_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            load_q <= load_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
            fs_q   <= fs_d;
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign frame_start = fs_q;

endmodule
